regbus_master: RTL and testbench

Bus initiator for the team's custom register bus (addr / chip_select / write_en / read_en / write_data / read_data / data_valid). It accepts single read or write commands on a valid/ready command port and runs each one as a bus transaction against a register-file slave. It then returns a response on a valid/ready response port. It sits between a CPU-side or script-driven command source and any generated register block.

---
 rtl/regbus_master.sv | 167 ++++++++++++++++
 tb/tb_regbus_master.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbus_master.sv
`default_nettype none
// ============================================================================
// Module   : regbus_master
// Purpose  : Runs single valid/ready read/write commands as register-bus
//            transactions and returns a valid/ready response. Defining
//            REGBUS_MASTER_TIMEOUT_EN adds a read timeout with rsp_error.
// Revision : 1.0 - initial release
// ============================================================================
module regbus_master #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  chip_select,
    output logic                  write_en,
    output logic                  read_en,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  data_valid
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    logic                  r_rsp_error;
    logic                  r_busy;
    logic                  r_cs;
    logic                  r_we;
    logic                  r_re;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic [DATA_WIDTH-1:0] w_rsp_rdata_nxt;
    logic                  w_rsp_error_nxt;
    logic                  w_cmd_fire;
    logic                  w_timeout;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("regbus_master: TIMEOUT_CYCLES must be within 2..255");
    end

`ifdef REGBUS_MASTER_TIMEOUT_EN
    localparam logic [7:0] c_timeout_max = 8'(TIMEOUT_CYCLES);

    // Counts strobe cycles of the current read; reads 1 in the first one.
    logic [7:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (w_state_nxt == S_READ) begin
            r_cnt <= (r_state == S_READ) ? r_cnt + 8'd1 : 8'd1;
        end else begin
            r_cnt <= 8'd0;
        end
    end

    assign w_timeout = (r_cnt == c_timeout_max);
`else
    assign w_timeout = 1'b0;
`endif

    assign w_cmd_fire = cmd_valid && r_cmd_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_error_nxt = r_rsp_error;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_fire) begin
                    w_state_nxt = cmd_write ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                w_state_nxt     = S_RESP;
                w_rsp_rdata_nxt = '0;
                w_rsp_error_nxt = 1'b0;
            end
            S_READ: begin
                // data_valid is checked first so it wins over a same-cycle timeout.
                if (data_valid) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_rdata_nxt = read_data;
                    w_rsp_error_nxt = 1'b0;
                end else if (w_timeout) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_error_nxt = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_cs        <= 1'b0;
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_cs        <= (w_state_nxt == S_WRITE) || (w_state_nxt == S_READ);
            r_we        <= (w_state_nxt == S_WRITE);
            r_re        <= (w_state_nxt == S_READ);
            r_rsp_valid <= (w_state_nxt == S_RESP);
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_error <= w_rsp_error_nxt;
            if (w_cmd_fire) begin
                r_addr  <= cmd_addr;
                r_wdata <= cmd_wdata;
            end
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign busy        = r_busy;
    assign chip_select = r_cs;
    assign write_en    = r_we;
    assign read_en     = r_re;
    assign addr        = r_addr;
    assign write_data  = r_wdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_error   = r_rsp_error;

endmodule
`default_nettype wire

// File: tb/tb_regbus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_regbus_master
// Purpose  : Directed self-checking bench for regbus_master with a register
//            file slave whose read acknowledge latency is adjustable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regbus_master;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic          busy;
    logic [AW-1:0] addr;
    logic          chip_select;
    logic          write_en;
    logic          read_en;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data;
    logic          data_valid;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            dv_lat  = 1;   // 0 = slave never acknowledges
    int            sl_cnt;
    logic [DW-1:0] mem [256];

    always #5 clk = ~clk;

    regbus_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .busy        (busy),
        .addr        (addr),
        .chip_select (chip_select),
        .write_en    (write_en),
        .read_en     (read_en),
        .write_data  (write_data),
        .read_data   (read_data),
        .data_valid  (data_valid)
    );

    assign read_data = (chip_select && read_en) ? mem[addr] : '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sl_cnt     <= 0;
            data_valid <= 1'b0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[8] <= 32'hDEAD_BEEF;
        end else begin
            if (chip_select && write_en) mem[addr] <= write_data;
            if (chip_select && read_en && !data_valid) begin
                sl_cnt     <= sl_cnt + 1;
                data_valid <= (dv_lat != 0) && (sl_cnt + 1 == dv_lat);
            end else begin
                sl_cnt     <= 0;
                data_valid <= 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Presents one command and returns just after the handshake edge (cycle 0).
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int waited = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_eq("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
    endtask

    task automatic trace(input int n, output int re_cnt, output int first,
                         output logic err, output logic [DW-1:0] rd);
        re_cnt = 0;
        first  = 0;
        err    = 1'b0;
        rd     = '0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (read_en) re_cnt++;
            if (rsp_valid && first == 0) begin
                first = k;
                err   = rsp_error;
                rd    = rsp_rdata;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int            re_cnt;
        int            first;
        logic          err;
        logic [DW-1:0] rd;
        int            idx;
        int            nresp;
        int            overlap;
        int            rcyc [3];
        logic [DW-1:0] rdat [3];
        logic          fire;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("rst_flags", 32'({rsp_valid, rsp_error, busy, chip_select, write_en, read_en}), 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("rst_addr", 32'(addr), 32'd0);
        check_eq("rst_write_data", write_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready_busy", 32'({cmd_ready, busy}), 32'b10);

        // Write
        issue(1'b1, 8'h04, 32'hA5A5_0001);
        @(negedge clk);
        check_eq("wr_c1_strobes", 32'({chip_select, write_en, read_en}), 32'b110);
        check_eq("wr_c1_addr", 32'(addr), 32'h04);
        check_eq("wr_c1_wdata", write_data, 32'hA5A5_0001);
        check_eq("wr_c1_busy_rdy_rsp", 32'({busy, cmd_ready, rsp_valid}), 32'b100);
        @(negedge clk);
        check_eq("wr_c2_strobes", 32'({chip_select, write_en, read_en}), 32'b000);
        check_eq("wr_c2_rsp", 32'({rsp_valid, rsp_error}), 32'b10);
        check_eq("wr_c2_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        check_eq("wr_c3_idle", 32'({rsp_valid, cmd_ready, busy}), 32'b010);

        // Read, standard slave
        issue(1'b0, 8'h08, 32'h0);
        @(negedge clk);
        check_eq("rd_c1_strobes", 32'({chip_select, write_en, read_en}), 32'b101);
        check_eq("rd_c1_addr", 32'(addr), 32'h08);
        @(negedge clk);
        check_eq("rd_c2_strobes_dv", 32'({chip_select, read_en, data_valid, rsp_valid}), 32'b1110);
        @(negedge clk);
        check_eq("rd_c3_strobes", 32'({chip_select, write_en, read_en}), 32'b000);
        check_eq("rd_c3_rsp", 32'({rsp_valid, rsp_error}), 32'b10);
        check_eq("rd_c3_rdata", rsp_rdata, 32'hDEAD_BEEF);

        // Acknowledge lands in the last allowed strobe cycle: data wins
        dv_lat = TO - 1;
        issue(1'b0, 8'h08, 32'h0);
        trace(30, re_cnt, first, err, rd);
        check_eq("late_dv_re_cycles", 32'(re_cnt), 32'(TO));
        check_eq("late_dv_rsp_cycle", 32'(first), 32'(TO + 1));
        check_eq("late_dv_error", 32'(err), 32'd0);
        check_eq("late_dv_rdata", rd, 32'hDEAD_BEEF);

        // Silent slave
        dv_lat = 0;
        issue(1'b0, 8'h10, 32'h0);
`ifdef REGBUS_MASTER_TIMEOUT_EN
        trace(30, re_cnt, first, err, rd);
        check_eq("to_re_cycles", 32'(re_cnt), 32'(TO));
        check_eq("to_rsp_cycle", 32'(first), 32'(TO + 1));
        check_eq("to_error", 32'(err), 32'd1);
        check_eq("to_rdata", rd, 32'd0);
`else
        trace(100, re_cnt, first, err, rd);
        check_eq("hang_re_cycles", 32'(re_cnt), 32'd100);
        check_eq("hang_no_rsp", 32'(first), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif
        dv_lat = 1;

        // Backpressure on the response
        rsp_ready = 1'b0;
        issue(1'b0, 8'h08, 32'h0);
        repeat (2) @(negedge clk);
        for (int k = 3; k <= 7; k++) begin
            @(negedge clk);
            check_eq("bp_rsp_hold", 32'({rsp_valid, rsp_error}), 32'b10);
            check_eq("bp_rdata_hold", rsp_rdata, 32'hDEAD_BEEF);
            check_eq("bp_no_accept_no_strobe", 32'({cmd_ready, chip_select, write_en, read_en}), 32'd0);
            if (k == 3) begin
                cmd_valid = 1'b1;
                cmd_write = 1'b1;
                cmd_addr  = 8'h0C;
                cmd_wdata = 32'h1234_5678;
            end
        end
        @(negedge clk);
        check_eq("bp_c8_still_waiting", 32'({rsp_valid, cmd_ready, chip_select}), 32'b100);
        rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_c9_ready", 32'({cmd_ready, rsp_valid, chip_select}), 32'b100);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        @(negedge clk);
        check_eq("bp_c10_write_strobe", 32'({chip_select, write_en, read_en}), 32'b110);
        check_eq("bp_c10_addr_data", write_data ^ 32'(addr), 32'h1234_5678 ^ 32'h0C);
        @(negedge clk);
        check_eq("bp_c11_rsp", 32'({rsp_valid, rsp_error}), 32'b10);

        // Reset in the middle of a read
        issue(1'b0, 8'h08, 32'h0);
        check_eq("rr_c1_read_en", 32'(read_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("rr_async_drop", 32'({chip_select, read_en, busy}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nresp = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) nresp++;
        end
        check_eq("rr_no_response", 32'(nresp), 32'd0);
        issue(1'b1, 8'h20, 32'h0000_0055);
        @(negedge clk);
        check_eq("rr_wr_c1", 32'({chip_select, write_en, rsp_valid}), 32'b110);
        @(negedge clk);
        check_eq("rr_wr_c2", 32'({rsp_valid, rsp_error, chip_select}), 32'b100);

        // Back-to-back: write 0x1, read 0x1, write 0x2
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        idx     = 0;
        nresp   = 0;
        overlap = 0;
        for (int i = 0; i < 3; i++) begin
            rcyc[i] = -1;
            rdat[i] = 32'hFFFF_FFFF;
        end
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h01;
        cmd_wdata = 32'hCAFE_0001;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            if (write_en && read_en) overlap++;
            if (rsp_valid && nresp < 3) begin
                rcyc[nresp] = c;
                rdat[nresp] = rsp_rdata;
                nresp++;
            end
            fire = cmd_valid && cmd_ready;
            @(posedge clk);
            #1;
            if (fire) begin
                idx++;
                if (idx == 1) begin
                    cmd_write = 1'b0;
                    cmd_addr  = 8'h01;
                    cmd_wdata = '0;
                end else if (idx == 2) begin
                    cmd_write = 1'b1;
                    cmd_addr  = 8'h02;
                    cmd_wdata = 32'hBEEF_0002;
                end else begin
                    cmd_valid = 1'b0;
                    cmd_write = 1'b0;
                end
            end
        end
        check_eq("b2b_resp_count", 32'(nresp), 32'd3);
        check_eq("b2b_resp0_cycle", 32'(rcyc[0]), 32'd2);
        check_eq("b2b_resp1_cycle", 32'(rcyc[1]), 32'd6);
        check_eq("b2b_resp2_cycle", 32'(rcyc[2]), 32'd9);
        check_eq("b2b_resp0_rdata", rdat[0], 32'd0);
        check_eq("b2b_resp1_rdata", rdat[1], 32'hCAFE_0001);
        check_eq("b2b_resp2_rdata", rdat[2], 32'd0);
        check_eq("b2b_no_overlap", 32'(overlap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
